// File: rtl/mem_arb_pkg.sv
// Shared types and width helpers for the unified-memory port arbiter.
// Imported by the arbiter top and its starvation counter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_t;

   typedef enum logic {
      OWN_IF,
      OWN_DM
   } owner_t;

   localparam int BYTE_W = 8;

   // Bits needed to hold the values 0..max_val.
   function automatic int cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory bus bundle for the fetch/data port arbiter.
// slave: arbiter view; master: pipeline + memory view.
interface mem_arb_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ack;
   logic              if_stall;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [BE_W-1:0]   dm_be;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_ack;
   logic              dm_stall;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [BE_W-1:0]   mem_be;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr,
      input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
      input  mem_rdata,
      output if_rdata, if_ack, if_stall,
      output dm_rdata, dm_ack, dm_stall,
      output mem_en, mem_we, mem_addr, mem_wdata, mem_be
   );

   modport master (
      output if_req, if_addr,
      output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
      output mem_rdata,
      input  if_rdata, if_ack, if_stall,
      input  dm_rdata, dm_ack, dm_stall,
      input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
   );

endinterface

// File: rtl/mem_port_arbiter_starve.sv
// Saturating count of back-to-back data grants taken while fetch waits.
// limit_hit_o hands the next contested grant to fetch.
module arb_starve_counter
   import mem_arb_pkg::*;
#(
   parameter int LIMIT = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic inc_i,
   input  logic clr_i,
   output logic limit_hit_o
);

   localparam int CW = cnt_w(LIMIT);
   localparam logic [CW-1:0] MAX = CW'(LIMIT);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign limit_hit_o = (cnt_q == MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between fetch and data.
// Data wins contested grants until fetch has waited STARVE_LIMIT times.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   mem_arb_if.slave   bus
);

   localparam int BE_W  = DATA_W / BYTE_W;
   localparam int LAT_W = cnt_w(MEM_LATENCY);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY);

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              if_ack_q, if_ack_d;
   logic              dm_ack_q, dm_ack_d;

   logic limit_hit;
   logic st_inc;
   logic st_clr;
   logic gnt_dm;

   arb_starve_counter #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .inc_i       (st_inc),
      .clr_i       (st_clr),
      .limit_hit_o (limit_hit)
   );

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      lat_d      = lat_q;
      mem_en_d   = 1'b0;
      mem_we_d   = mem_we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      if_ack_d   = 1'b0;
      dm_ack_d   = 1'b0;
      st_inc     = 1'b0;
      st_clr     = 1'b0;
      gnt_dm     = bus.dm_req & (~bus.if_req | ~limit_hit);

      unique case (state_q)
         IDLE: begin
            if (bus.dm_req | bus.if_req) begin
               state_d  = WAIT;
               lat_d    = '0;
               mem_en_d = 1'b1;
               if (gnt_dm) begin
                  owner_d  = OWN_DM;
                  mem_we_d = bus.dm_we;
                  addr_d   = bus.dm_addr;
                  wdata_d  = bus.dm_wdata;
                  be_d     = bus.dm_be;
                  st_inc   = bus.if_req;
                  st_clr   = ~bus.if_req;
               end else begin
                  owner_d  = OWN_IF;
                  mem_we_d = 1'b0;
                  addr_d   = bus.if_addr;
                  be_d     = '1;
                  st_clr   = 1'b1;
               end
            end
         end
         WAIT: begin
            if (lat_q == LAT_LAST) begin
               state_d = DONE;
               if (owner_q == OWN_IF) begin
                  if_rdata_d = bus.mem_rdata;
                  if_ack_d   = 1'b1;
               end else begin
                  dm_ack_d = 1'b1;
                  // Writes leave the last read result visible.
                  if (!mem_we_q) begin
                     dm_rdata_d = bus.mem_rdata;
                  end
               end
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         owner_q    <= OWN_IF;
         lat_q      <= '0;
         mem_en_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
         if_ack_q   <= 1'b0;
         dm_ack_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         lat_q      <= lat_d;
         mem_en_q   <= mem_en_d;
         mem_we_q   <= mem_we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
         if_ack_q   <= if_ack_d;
         dm_ack_q   <= dm_ack_d;
      end
   end

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_be    = be_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.if_ack    = if_ack_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.dm_ack    = dm_ack_q;
   assign bus.if_stall  = bus.if_req & ~if_ack_q;
   assign bus.dm_stall  = bus.dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of grants, latency and memory contents.
module tb_mem_port_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LAT = 2;
   localparam int SL  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;

   mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_arbiter #(
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .MEM_LATENCY  (LAT),
      .STARVE_LIMIT (SL)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] pipe [LAT];

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{be[i]}};
      return (old & ~m) | (wd & m);
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : dflt(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   function automatic logic [31:0] raddr();
      return 32'h1000 + ($urandom_range(15) << 2);
   endfunction

   // Fixed-latency memory: data read at the mem_en cycle appears LAT cycles later.
   always @(posedge clk) begin
      logic [31:0] rd;
      rd = 32'h0BAD0BAD;
      if (bus.mem_en) begin
         rd = mem_rd(bus.mem_addr);
         if (bus.mem_we) mem[bus.mem_addr] = merge(rd, bus.mem_wdata, bus.mem_be);
      end
      pipe[0] <= rd;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end

   assign bus.mem_rdata = pipe[LAT-1];

   task automatic idle_inputs();
      bus.if_req   = 1'b0;
      bus.if_addr  = '0;
      bus.dm_req   = 1'b0;
      bus.dm_we    = 1'b0;
      bus.dm_addr  = '0;
      bus.dm_wdata = '0;
      bus.dm_be    = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic new_dm();
      bus.dm_we    = 1'($urandom_range(1));
      bus.dm_addr  = raddr();
      bus.dm_wdata = $urandom;
      bus.dm_be    = 4'($urandom_range(15, 1));
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== '0) begin
         failures++;
         $display("FAIL reset_mem got=%0h exp=0", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be});
      end
      checks++;
      if ({bus.if_ack, bus.dm_ack, bus.if_rdata, bus.dm_rdata} !== '0) begin
         failures++;
         $display("FAIL reset_resp got=%0h exp=0", {bus.if_ack, bus.dm_ack, bus.if_rdata, bus.dm_rdata});
      end
      bus.if_req = 1'b1;
      bus.dm_req = 1'b1;
      #1;
      checks++;
      if ({bus.if_stall, bus.dm_stall} !== 2'b11) begin
         failures++;
         $display("FAIL reset_stall got=%b exp=11", {bus.if_stall, bus.dm_stall});
      end
      idle_inputs();
   endtask

   task automatic test_single_fetch();
      do_reset();
      mem[32'h10] = 32'h8C220004;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h10;
      #1;
      checks++;
      if (bus.if_stall !== 1'b1) begin
         failures++;
         $display("FAIL fetch_stall_c0 got=%b exp=1", bus.if_stall);
      end
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         checks++;
         if (bus.mem_en !== (c == 1)) begin
            failures++;
            $display("FAIL fetch_en c=%0d got=%b exp=%b", c, bus.mem_en, c == 1);
         end
         checks++;
         if (bus.if_ack !== (c == 4)) begin
            failures++;
            $display("FAIL fetch_ack c=%0d got=%b exp=%b", c, bus.if_ack, c == 4);
         end
         if (c == 1) begin
            checks++;
            if ({bus.mem_addr, bus.mem_we, bus.mem_be} !== {32'h10, 1'b0, 4'hF}) begin
               failures++;
               $display("FAIL fetch_issue got=%h/%b/%h exp=10/0/f", bus.mem_addr, bus.mem_we, bus.mem_be);
            end
         end
         if (c < 4) begin
            checks++;
            if (bus.if_stall !== 1'b1) begin
               failures++;
               $display("FAIL fetch_stall c=%0d got=%b exp=1", c, bus.if_stall);
            end
         end
         if (c == 4) begin
            checks++;
            if (bus.if_rdata !== 32'h8C220004) begin
               failures++;
               $display("FAIL fetch_rdata got=%h exp=8c220004", bus.if_rdata);
            end
            bus.if_req = 1'b0;
         end
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      bus.dm_req   = 1'b1;
      bus.dm_we    = 1'b1;
      bus.dm_addr  = 32'h100;
      bus.dm_wdata = 32'hDEADBEEF;
      bus.dm_be    = 4'hF;
      bus.if_req   = 1'b1;
      bus.if_addr  = 32'h40;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         checks++;
         if (bus.mem_en !== (c == 1 || c == 6)) begin
            failures++;
            $display("FAIL sim_en c=%0d got=%b", c, bus.mem_en);
         end
         checks++;
         if ({bus.dm_ack, bus.if_ack} !== {c == 4, c == 9}) begin
            failures++;
            $display("FAIL sim_ack c=%0d got=%b exp=%b", c, {bus.dm_ack, bus.if_ack}, {c == 4, c == 9});
         end
         if (c == 1) begin
            checks++;
            if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== {1'b1, 32'h100, 32'hDEADBEEF, 4'hF}) begin
               failures++;
               $display("FAIL sim_dm_issue got=%b/%h/%h/%h", bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be);
            end
         end
         if (c == 4) begin
            checks++;
            if (bus.dm_rdata !== 32'h0) begin
               failures++;
               $display("FAIL sim_wr_rdata got=%h exp=0", bus.dm_rdata);
            end
            bus.dm_req = 1'b0;
         end
         if (c == 6) begin
            checks++;
            if ({bus.mem_we, bus.mem_addr, bus.mem_be} !== {1'b0, 32'h40, 4'hF}) begin
               failures++;
               $display("FAIL sim_if_issue got=%b/%h/%h", bus.mem_we, bus.mem_addr, bus.mem_be);
            end
         end
         if (c == 9) bus.if_req = 1'b0;
      end
   endtask

   task automatic test_starvation();
      bit seq [6];
      int n = 0;
      do_reset();
      bus.dm_req  = 1'b1;
      bus.dm_addr = 32'h300;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h50;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (bus.mem_en) begin
            if (n < 6) seq[n] = (bus.mem_addr == 32'h300);
            n++;
         end
         if (bus.if_ack) begin
            checks++;
            if (bus.if_stall !== 1'b0) begin
               failures++;
               $display("FAIL starve_stall_at_ack got=%b exp=0", bus.if_stall);
            end
         end
      end
      checks++;
      if (n != 6) begin
         failures++;
         $display("FAIL starve_grants got=%0d exp=6", n);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (seq[i] !== ((i % (SL + 1)) != SL)) begin
            failures++;
            $display("FAIL starve_order i=%0d got_dm=%b exp_dm=%b", i, seq[i], (i % (SL + 1)) != SL);
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.dm_req  = 1'b1;
      bus.dm_addr = 32'h80;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be,
           bus.if_ack, bus.dm_ack, bus.if_rdata, bus.dm_rdata} !== '0) begin
         failures++;
         $display("FAIL rstmid_clear addr=%h en=%b exp=0", bus.mem_addr, bus.mem_en);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 1; c <= LAT + 2; c++) begin
         @(negedge clk);
         checks++;
         if (bus.dm_ack !== (c == LAT + 2)) begin
            failures++;
            $display("FAIL rstmid_ack c=%0d got=%b exp=%b", c, bus.dm_ack, c == LAT + 2);
         end
      end
      checks++;
      if (bus.dm_rdata !== mem_rd(32'h80)) begin
         failures++;
         $display("FAIL rstmid_rdata got=%h exp=%h", bus.dm_rdata, mem_rd(32'h80));
      end
      idle_inputs();
   endtask

   task automatic test_byte_write();
      do_reset();
      mem[32'h204] = 32'h11223344;
      bus.dm_req   = 1'b1;
      bus.dm_we    = 1'b1;
      bus.dm_addr  = 32'h204;
      bus.dm_wdata = 32'h0000AB00;
      bus.dm_be    = 4'h2;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         checks++;
         if (bus.dm_ack !== (c == 4 || c == 9)) begin
            failures++;
            $display("FAIL bw_ack c=%0d got=%b", c, bus.dm_ack);
         end
         if (c == 1) begin
            checks++;
            if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata} !==
                {2'b11, 32'h204, 4'h2, 32'h0000AB00}) begin
               failures++;
               $display("FAIL bw_issue got=%h/%h/%h", bus.mem_addr, bus.mem_be, bus.mem_wdata);
            end
         end
         if (c == 4) bus.dm_we = 1'b0;
         if (c == 9) begin
            checks++;
            if (bus.dm_rdata !== 32'h1122AB44) begin
               failures++;
               $display("FAIL bw_readback got=%h exp=1122ab44", bus.dm_rdata);
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_redirect();
      do_reset();
      bus.dm_req  = 1'b1;
      bus.dm_addr = 32'h300;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h18;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         if (c == 2) bus.if_addr = 32'h20;
         if (c == 4) bus.dm_req = 1'b0;
         if (c == 6) begin
            checks++;
            if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {2'b10, 32'h20}) begin
               failures++;
               $display("FAIL redir_issue got=%b/%b/%h exp=1/0/20", bus.mem_en, bus.mem_we, bus.mem_addr);
            end
         end
         if (c == 9) begin
            checks++;
            if ({bus.if_ack, bus.if_rdata} !== {1'b1, mem_rd(32'h20)}) begin
               failures++;
               $display("FAIL redir_ack got=%b/%h exp=1/%h", bus.if_ack, bus.if_rdata, mem_rd(32'h20));
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_random();
      bit busy = 1'b0;
      bit own_dm = 1'b0;
      bit fr;
      int t = 0;
      int streak = 0;
      logic [31:0] g_addr = '0;
      logic [31:0] g_wd = '0;
      logic [31:0] last_dm = '0;
      logic [3:0] g_be = '0;
      logic g_we = 1'b0;
      logic e_en, e_ia, e_da;
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         e_en = 1'b0;
         e_ia = 1'b0;
         e_da = 1'b0;
         if (busy) begin
            t++;
            e_en = (t == 1);
            e_ia = (t == LAT + 2) && !own_dm;
            e_da = (t == LAT + 2) && own_dm;
         end
         checks++;
         if (bus.mem_en !== e_en) begin
            failures++;
            $display("FAIL rnd_en k=%0d got=%b exp=%b", k, bus.mem_en, e_en);
         end
         if (e_en) begin
            checks++;
            if ({bus.mem_addr, bus.mem_we, bus.mem_be} !== {g_addr, g_we, g_be}) begin
               failures++;
               $display("FAIL rnd_issue k=%0d got=%h/%b/%h exp=%h/%b/%h", k,
                        bus.mem_addr, bus.mem_we, bus.mem_be, g_addr, g_we, g_be);
            end
            if (g_we) begin
               checks++;
               if (bus.mem_wdata !== g_wd) begin
                  failures++;
                  $display("FAIL rnd_wdata k=%0d got=%h exp=%h", k, bus.mem_wdata, g_wd);
               end
            end
         end
         checks++;
         if ({bus.if_ack, bus.dm_ack} !== {e_ia, e_da}) begin
            failures++;
            $display("FAIL rnd_ack k=%0d got=%b exp=%b", k, {bus.if_ack, bus.dm_ack}, {e_ia, e_da});
         end
         if (e_ia) begin
            checks++;
            if (bus.if_rdata !== ref_rd(g_addr)) begin
               failures++;
               $display("FAIL rnd_if_rdata k=%0d got=%h exp=%h", k, bus.if_rdata, ref_rd(g_addr));
            end
         end
         if (e_da) begin
            if (g_we) ref_mem[g_addr] = merge(ref_rd(g_addr), g_wd, g_be);
            else last_dm = ref_rd(g_addr);
            checks++;
            if (bus.dm_rdata !== last_dm) begin
               failures++;
               $display("FAIL rnd_dm_rdata k=%0d got=%h exp=%h", k, bus.dm_rdata, last_dm);
            end
         end
         fr = !busy;
         if (t == LAT + 2) begin
            busy = 1'b0;
            t = 0;
         end
         if (e_ia) begin
            bus.if_req  = 1'($urandom_range(1));
            bus.if_addr = raddr();
         end else if (!bus.if_req) begin
            if ($urandom_range(3) == 0) begin
               bus.if_req  = 1'b1;
               bus.if_addr = raddr();
            end
         end else if (!(busy && !own_dm)) begin
            case ($urandom_range(7))
               0: bus.if_req = 1'b0;
               1: bus.if_addr = raddr();
               default: ;
            endcase
         end
         if (e_da) begin
            bus.dm_req = 1'($urandom_range(1));
            new_dm();
         end else if (!bus.dm_req) begin
            if ($urandom_range(2) == 0) begin
               bus.dm_req = 1'b1;
               new_dm();
            end
         end else if (!(busy && own_dm)) begin
            if ($urandom_range(9) == 0) bus.dm_req = 1'b0;
         end
         #1;
         checks++;
         if ({bus.if_stall, bus.dm_stall} !== {bus.if_req & ~e_ia, bus.dm_req & ~e_da}) begin
            failures++;
            $display("FAIL rnd_stall k=%0d got=%b exp=%b", k, {bus.if_stall, bus.dm_stall},
                     {bus.if_req & ~e_ia, bus.dm_req & ~e_da});
         end
         if (fr && (bus.if_req || bus.dm_req)) begin
            if (bus.dm_req && (!bus.if_req || streak < SL)) begin
               own_dm = 1'b1;
               g_addr = bus.dm_addr;
               g_we   = bus.dm_we;
               g_wd   = bus.dm_wdata;
               g_be   = bus.dm_be;
               streak = bus.if_req ? streak + 1 : 0;
            end else begin
               own_dm = 1'b0;
               g_addr = bus.if_addr;
               g_we   = 1'b0;
               g_be   = 4'hF;
               streak = 0;
            end
            busy = 1'b1;
            t = 0;
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_simultaneous();
      test_starvation();
      test_reset_mid();
      test_byte_write();
      test_redirect();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch (IF) requester and the data-memory (MEM stage) requester of the 5-stage pipeline.
- Sequences each access through a fixed-latency memory: issue, wait, capture, acknowledge.
- Per-requester stall outputs feed the pipeline's stall logic.
- Data has priority because it belongs to the older instruction; a starvation limit guarantees forward progress for fetch.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- MEM_LATENCY, 2, cycles from a mem_en cycle to valid mem_rdata; legal values >=1.
- STARVE_LIMIT, 4, maximum consecutive data grants while if_req is pending; legal values >=1.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word; valid while if_ack=1.
- if_ack  out  1  one-cycle completion pulse.
- if_stall  out  1  if_req & ~if_ack.
- dm_req  in  1  data request; held until dm_ack.
- dm_we  in  1  1=write, 0=read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_be  in  DATA_W/8  byte enables for writes.
- dm_rdata  out  DATA_W  read data; valid while dm_ack=1.
- dm_ack  out  1  one-cycle completion pulse.
- dm_stall  out  1  dm_req & ~dm_ack.
- mem_en  out  1  one-cycle access strobe to memory.
- mem_we  out  1  write strobe; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_rdata  in  DATA_W  read data, valid MEM_LATENCY cycles after mem_en.

Behaviour:
- Clock and reset: single clock Clk. Reset is asynchronous and active-high. While Reset=1:
  - all registered outputs are 0;
  - FSM is IDLE;
  - latency and starvation counters are 0;
  - an in-flight access is discarded and never acknowledged.
- All outputs except if_stall and dm_stall are registered. The stalls are combinational.
- FSM states are IDLE, WAIT and DONE.
- IDLE:
  - Arbitrate when any request is high.
  - dm_req only: grant data. if_req only: grant fetch.
  - Both high: grant data if starve_cnt < STARVE_LIMIT, otherwise grant fetch.
  - At the grant edge, latch owner, address, we, wdata and be. Drive mem_en=1 for exactly the first WAIT cycle.
  - Fetch grants force mem_we=0 and mem_be=all ones.
- WAIT:
  - lat_cnt starts at 0 and increments each cycle.
  - When lat_cnt==MEM_LATENCY, capture mem_rdata into the owner's rdata register and go to DONE.
- DONE:
  - Owner's ack=1 for one cycle; go to IDLE.
  - No arbitration in DONE, so a still-high req is not regranted.
- Timing: a request seen in IDLE at cycle 0 gets mem_en in cycle 1 and ack in cycle MEM_LATENCY+2. The earliest next grant is the cycle after ack, so back-to-back throughput is one access per MEM_LATENCY+3 cycles.
- Writes use the same timing. The ack confirms completion. dm_rdata keeps its previous value on writes.
- starve_cnt:
  - increments on a data grant while if_req=1, saturating at STARVE_LIMIT;
  - clears on any fetch grant, or on a data grant with if_req=0.
- Address sampling: addresses and data are sampled only at the grant edge. A requester may change or drop an ungranted request, e.g. on a branch redirect. Dropping a granted request before ack is a protocol violation: ack is still delivered and the bench flags it.
- mem_addr, mem_wdata and mem_be hold their last values outside mem_en.
- Reset released mid-sequence: the first grant follows normal IDLE rules on the first edge with Reset=0.

Decomposition:
- Package mem_arb_pkg holds:
  - FSM state encoding (IDLE, WAIT, DONE);
  - owner encoding (OWN_IF, OWN_DM);
  - width helper constants.
- One sub-module, arb_starve_counter: saturating counter with inc/clr inputs and a limit_hit output.
- FSM and datapath registers live in the top module.

Test Plan (MEM_LATENCY=2, STARVE_LIMIT=2):
1. **Single fetch.** if_req=1, if_addr=0x00000010 at cycle 0; memory returns 0x8C220004 in cycle 3 → mem_en=1, mem_addr=0x10, mem_we=0 in cycle 1; if_ack=1, if_rdata=0x8C220004 in cycle 4; if_stall=1 in cycles 0-3.
2. **Simultaneous requests.** Both requests at cycle 0; data write addr=0x100, wdata=0xDEADBEEF, be=0xF → data mem_en with mem_we=1 in cycle 1; dm_ack in cycle 4; fetch mem_en in cycle 6; if_ack in cycle 9.
3. **Starvation.** dm_req and if_req held continuously → grant order D,D,I,D,D,I.
4. **Reset mid-access.** Reset pulsed in cycle 2 of a read → all outputs 0 asynchronously; no ack after release; the re-issued request completes in MEM_LATENCY+2 cycles.
5. **Byte write.** dm_be=0x2, dm_wdata=0x0000AB00, addr=0x204 → mem_be=0x2, mem_addr=0x204 in the issue cycle.
6. **Redirected fetch.** Fetch waits behind a data access; if_addr changes from 0x18 to 0x20 before grant → fetch issues mem_addr=0x20.
